// File: rtl/ibex_if_dummy_stage.sv
// IF->ID stage register that inserts dummy instructions ahead of the pending real fetch; one cycle to ID.
// Holds its contents while ID stalls; a dummy load leaves the real instruction pending (fetch_ready_o low).
module ibex_if_dummy_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        insert_dummy_instr_i,
  input  logic [31:0] dummy_instr_data_i,
  output logic        id_in_ready_o,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] instr_addr_id_o,
  output logic        instr_fetch_err_o,
  output logic        instr_is_dummy_o,
  input  logic        dummy_cnt_clr_i,
  output logic [15:0] dummy_cnt_o
);

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } instr_t;

  instr_t      instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        is_dummy_q, is_dummy_d;
  logic [15:0] cnt_q, cnt_d;

  logic stage_free;
  logic load_dummy;
  logic load_real;

  assign stage_free    = ~valid_q | id_ready_i;
  assign id_in_ready_o = stage_free & ~flush_i & fetch_valid_i;
  assign load_dummy    = id_in_ready_o & insert_dummy_instr_i;
  assign load_real     = id_in_ready_o & ~insert_dummy_instr_i;
  assign fetch_ready_o = load_real;

  always_comb begin
    instr_d    = instr_q;
    valid_d    = valid_q;
    is_dummy_d = is_dummy_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      is_dummy_d = 1'b0;
    end else if (load_dummy) begin
      // Dummy carries the pending PC so ID sees a plausible address.
      instr_d.rdata = dummy_instr_data_i;
      instr_d.addr  = fetch_addr_i;
      instr_d.err   = 1'b0;
      valid_d       = 1'b1;
      is_dummy_d    = 1'b1;
    end else if (load_real) begin
      instr_d.rdata = fetch_rdata_i;
      instr_d.addr  = fetch_addr_i;
      instr_d.err   = fetch_err_i;
      valid_d       = 1'b1;
      is_dummy_d    = 1'b0;
    end else if (stage_free) begin
      valid_d    = 1'b0;
      is_dummy_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (dummy_cnt_clr_i) begin
      cnt_d = 16'h0000;
    end else if (load_dummy && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= '0;
      valid_q    <= 1'b0;
      is_dummy_q <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      is_dummy_q <= is_dummy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign instr_valid_id_o  = valid_q;
  assign instr_rdata_id_o  = instr_q.rdata;
  assign instr_addr_id_o   = instr_q.addr;
  assign instr_fetch_err_o = instr_q.err;
  assign instr_is_dummy_o  = is_dummy_q;
  assign dummy_cnt_o       = cnt_q;

endmodule

// File: doc/ibex_if_dummy_stage.md
IBEX_IF_DUMMY_STAGE -- requirements
Module: ibex_if_dummy_stage

Interface
REQ-001 Clock: clk_i, input, 1 bit, rising-edge clock for all state.
REQ-002 Reset: rst_ni, input, 1 bit; reset is asynchronous and active-low.
REQ-003 fetch_valid_i, input, 1 bit: the fetch unit presents a real instruction.
REQ-004 fetch_rdata_i, input, 32 bits: real instruction word.
REQ-005 fetch_addr_i, input, 32 bits: PC of the real instruction.
REQ-006 fetch_err_i, input, 1 bit: fetch bus error for the real instruction.
REQ-007 fetch_ready_o, output, 1 bit: the real instruction is consumed this cycle.
REQ-008 insert_dummy_instr_i, input, 1 bit: the dummy generator requests an insertion.
REQ-009 dummy_instr_data_i, input, 32 bits: dummy instruction encoding.
REQ-010 id_in_ready_o, output, 1 bit: the stage register can load this cycle; feeds the dummy generator's id_in_ready_i.
REQ-011 flush_i, input, 1 bit: kills the stage contents (branch, exception).
REQ-012 id_ready_i, input, 1 bit: the ID stage accepts the current output.
REQ-013 instr_valid_id_o, output, 1 bit: stage holds a valid instruction.
REQ-014 instr_rdata_id_o, output, 32 bits: instruction to ID.
REQ-015 instr_addr_id_o, output, 32 bits: PC associated with the output.
REQ-016 instr_fetch_err_o, output, 1 bit: error flag to ID.
REQ-017 instr_is_dummy_o, output, 1 bit: the output is a dummy instruction.
REQ-018 dummy_cnt_clr_i, input, 1 bit: synchronous clear of the dummy counter.
REQ-019 dummy_cnt_o, output, 16 bits: saturating count of dummies delivered to the stage register.

Function
REQ-020 stage_free = ~instr_valid_id_q | id_ready_i.
REQ-021 id_in_ready_o SHALL be stage_free & ~flush_i & fetch_valid_i (combinational, no latency).
REQ-022 Dummy load: if insert_dummy_instr_i & id_in_ready_o, then on the next edge the stage SHALL hold the following:
- rdata = dummy_instr_data_i
- addr = fetch_addr_i
- err = 0
- is_dummy = 1
- valid = 1
REQ-023 During a dummy load, fetch_ready_o SHALL be 0, so the real instruction stays pending upstream unchanged.
REQ-024 Real load: if ~insert_dummy_instr_i & id_in_ready_o, then:
- the stage SHALL load fetch_rdata_i, fetch_addr_i and fetch_err_i with is_dummy = 0 and valid = 1;
- fetch_ready_o SHALL be 1.
REQ-025 Dummy insertion has priority over the real instruction; consecutive dummy requests SHALL produce consecutive dummy loads.
REQ-026 Clear when empty: if stage_free & ~flush_i & ~fetch_valid_i, valid SHALL clear on the next edge, and nothing loads.
REQ-027 Hold: if instr_valid_id_q & ~id_ready_i & ~flush_i, all outputs SHALL hold stable and fetch_ready_o SHALL be 0.
REQ-028 Flush: flush_i SHALL clear valid and is_dummy on the next edge.
- flush_i overrides id_ready_i, fetch_valid_i and insert_dummy_instr_i.
- fetch_ready_o SHALL be 0 while flush_i is asserted.
REQ-029 Data fields (rdata, addr, err) SHALL update only on a load.
REQ-030 instr_valid_id_o and instr_is_dummy_o SHALL be registered outputs; fetch_ready_o and id_in_ready_o SHALL be combinational.
REQ-031 dummy_cnt_o increment and clear:
- SHALL increment by 1 on each dummy load;
- SHALL saturate at 16'hFFFF, with no wrap;
- dummy_cnt_clr_i SHALL clear it to 0 and wins over a simultaneous increment.

Reset
REQ-032 While rst_ni = 0, asynchronously and independent of clk_i:
- instr_valid_id_o = 0, instr_rdata_id_o = 0, instr_addr_id_o = 0;
- instr_fetch_err_o = 0, instr_is_dummy_o = 0;
- dummy_cnt_o = 0.
REQ-033 While rst_ni = 0, fetch_ready_o and id_in_ready_o SHALL follow their combinational definitions using the reset state.
REQ-034 Reset asserted mid-operation SHALL discard any held instruction; after release the first load SHALL occur on the first qualifying edge.

Verification
REQ-035 Real pass-through:
- stimulus: fetch_valid_i = 1, rdata 0x00A00093, addr 0x100, id_ready_i = 1, no insert;
- response: next cycle valid = 1, rdata 0x00A00093, addr 0x100, is_dummy = 0; fetch_ready_o = 1 in the load cycle.
REQ-036 Dummy insertion:
- stimulus: insert = 1, dummy data 0x02C58033, fetch_valid_i = 1 with addr 0x104;
- response: next cycle rdata 0x02C58033, addr 0x104, is_dummy = 1, dummy_cnt_o = 1; fetch_ready_o = 0 in the load cycle;
- following cycle, with insert = 0: the real instruction at 0x104 loads.
REQ-037 Stall:
- stimulus: valid output, id_ready_i = 0 for 3 cycles while insert = 1 and fetch_valid_i = 1;
- response: outputs unchanged, id_in_ready_o = 0, fetch_ready_o = 0, dummy_cnt_o unchanged.
REQ-038 Flush collision:
- stimulus: flush_i = 1 together with id_ready_i = 1, fetch_valid_i = 1, insert = 1;
- response: next cycle valid = 0, is_dummy = 0, no load, fetch_ready_o = 0, dummy_cnt_o unchanged.
REQ-039 Counter saturation:
- stimulus: preload via 65535 dummy loads, then 2 more loads;
- response: dummy_cnt_o = 0xFFFF; then dummy_cnt_clr_i plus a simultaneous dummy load gives 0.
REQ-040 Async reset:
- stimulus: drop rst_ni mid-cycle while valid = 1 with a dummy held;
- response: outputs 0 immediately, without a clock edge; the first load after release behaves as REQ-035.
